nx_outbound_arbiter: RTL

// - Shares one node outbound link (one direction of nx_node) between several message sources.
// - Sources are local output generation plus forwarded traffic from the inbound directions.
// - Selects one source per accepted message using fair round-robin, registers it into a

---
 rtl/nx_outbound_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nx_outbound_arbiter.sv
// Round-robin arbiter feeding one outbound link through a single-entry output slot.
// Define NX_OB_ARB_STATS_EN to add saturating drop/grant statistics counters.
//
// state    | meaning
// ST_EMPTY | slot free, o_out_valid=0
// ST_HOLD  | slot holds a message for the neighbour, o_out_valid=1
module nx_outbound_arbiter #(
  parameter int unsigned REQUESTERS = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [REQUESTERS-1:0][DATA_W-1:0]   i_req_data,
  input  logic [REQUESTERS-1:0]               i_req_valid,
  output logic [REQUESTERS-1:0]               o_req_ready,
  output logic [DATA_W-1:0]                   o_out_data,
  output logic                                o_out_valid,
  input  logic                                i_out_ready,
  input  logic                                i_out_present,
  output logic                                o_idle
`ifdef NX_OB_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]                    o_drop_count,
  output logic [CNT_W-1:0]                    o_grant_count
`endif
);

  localparam int unsigned PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(REQUESTERS - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand_idx;
  logic              grant_found;
  logic              slot_open;
  logic              transfer;
  logic [DATA_W-1:0] slot_data;
  int                cand;

  // Wrap uses an explicit compare so non-power-of-two REQUESTERS scan correctly.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= int'(REQUESTERS); k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= int'(REQUESTERS)) cand = cand - int'(REQUESTERS);
      cand_idx = PTR_W'(cand);
      if (!grant_found && i_req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    slot_open   = !i_out_present || (state == ST_EMPTY) || i_out_ready;
    o_req_ready = '0;
    if (slot_open && grant_found) o_req_ready[grant_idx] = 1'b1;
    transfer    = slot_open && grant_found;
    if (!i_out_present) begin
      state_nxt = ST_EMPTY;
    end else if (transfer) begin
      state_nxt = ST_HOLD;
    end else if ((state == ST_HOLD) && i_out_ready) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr    <= PTR_LAST;
      slot_data <= '0;
    end else if (transfer) begin
      rr_ptr <= grant_idx;
      if (i_out_present) slot_data <= i_req_data[grant_idx];
    end
  end

  assign o_out_valid = (state == ST_HOLD);
  assign o_out_data  = slot_data;
  assign o_idle      = !o_out_valid && !(|i_req_valid);

`ifdef NX_OB_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] grant_cnt;
  logic [1:0]       drop_inc;

  // A held message and a newly accepted one can both be discarded in one cycle.
  assign drop_inc = {1'b0, o_out_valid && !i_out_present} + {1'b0, transfer && !i_out_present};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drop_cnt  <= '0;
      grant_cnt <= '0;
    end else begin
      if (drop_cnt > CNT_MAX - CNT_W'(drop_inc)) drop_cnt <= CNT_MAX;
      else                                         drop_cnt <= drop_cnt + CNT_W'(drop_inc);
      if (o_out_valid && i_out_ready && (grant_cnt != CNT_MAX))
        grant_cnt <= grant_cnt + CNT_W'(1);
    end
  end

  assign o_drop_count  = drop_cnt;
  assign o_grant_count = grant_cnt;
`else
  if (CNT_W == 0) begin : g_no_stats
  end
`endif

endmodule
